// File: rtl/square_seq_ctrl.sv
// Frame-synchronous size/color controller for the square renderer.
// Manual mode applies shadow registers; auto mode ping-pongs size and rotates color.
module square_seq_ctrl #(
  parameter int PERIOD_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        write,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        frame_start,
  output logic [1:0]  sq_size,
  output logic [11:0] sq_color,
  output logic        step_tick
);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_UP     = 2'd1,
    ST_DOWN   = 2'd2,
    ST_BAD    = 2'd3
  } state_t;

  logic                autoEn_q;
  logic                pause_q;
  logic [1:0]          manSize_q;
  logic [11:0]         manColor_q;
  logic [PERIOD_W-1:0] period_q;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] frameCnt_q, frameCnt_d;
  logic [1:0]          sqSize_q, sqSize_d;
  logic [11:0]         sqColor_q, sqColor_d;
  logic                stepTick_q, stepTick_d;

  logic [PERIOD_W-1:0] effPeriod;
  logic [PERIOD_W:0]   cntPlusOne;
  logic                stepDue;

  // Bus-programmable registers; a write lands on the edge that samples it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      autoEn_q   <= 1'b0;
      pause_q    <= 1'b0;
      manSize_q  <= 2'd0;
      manColor_q <= 12'hF00;
      period_q   <= PERIOD_W'(60);
    end else if (cs && write) begin
      case (addr)
        2'd0: begin
          autoEn_q <= wr_data[0];
          pause_q  <= wr_data[1];
        end
        2'd1: manSize_q  <= wr_data[1:0];
        2'd2: manColor_q <= wr_data[11:0];
        default: period_q <= wr_data[PERIOD_W-1:0];
      endcase
    end
  end

  // A zero period behaves as one; the extra bit keeps the +1 from wrapping.
  assign effPeriod  = (period_q == '0) ? PERIOD_W'(1) : period_q;
  assign cntPlusOne = {1'b0, frameCnt_q} + {{PERIOD_W{1'b0}}, 1'b1};
  assign stepDue    = (cntPlusOne >= {1'b0, effPeriod});

  always_comb begin
    state_d    = state_q;
    frameCnt_d = frameCnt_q;
    sqSize_d   = sqSize_q;
    sqColor_d  = sqColor_q;
    stepTick_d = 1'b0;
    if (frame_start) begin
      case (state_q)
        ST_MANUAL: begin
          frameCnt_d = '0;
          if (autoEn_q) begin
            state_d = ST_UP;
          end else begin
            sqSize_d  = manSize_q;
            sqColor_d = manColor_q;
          end
        end
        ST_UP, ST_DOWN: begin
          // Leaving auto mode wins over pause so the shadows load immediately.
          if (!autoEn_q) begin
            state_d    = ST_MANUAL;
            frameCnt_d = '0;
            sqSize_d   = manSize_q;
            sqColor_d  = manColor_q;
          end else if (!pause_q) begin
            if (stepDue) begin
              frameCnt_d = '0;
              stepTick_d = 1'b1;
              sqColor_d  = {sqColor_q[7:0], sqColor_q[11:8]};
              if (state_q == ST_UP) begin
                if (sqSize_q == 2'd3) begin
                  state_d  = ST_DOWN;
                  sqSize_d = 2'd2;
                end else begin
                  sqSize_d = sqSize_q + 2'd1;
                end
              end else begin
                if (sqSize_q == 2'd0) begin
                  state_d  = ST_UP;
                  sqSize_d = 2'd1;
                end else begin
                  sqSize_d = sqSize_q - 2'd1;
                end
              end
            end else begin
              frameCnt_d = cntPlusOne[PERIOD_W-1:0];
            end
          end
        end
        default: begin
          state_d    = ST_MANUAL;
          frameCnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_MANUAL;
      frameCnt_q <= '0;
      sqSize_q   <= 2'd0;
      sqColor_q  <= 12'hF00;
      stepTick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frameCnt_q <= frameCnt_d;
      sqSize_q   <= sqSize_d;
      sqColor_q  <= sqColor_d;
      stepTick_q <= stepTick_d;
    end
  end

  assign sq_size   = sqSize_q;
  assign sq_color  = sqColor_q;
  assign step_tick = stepTick_q;

  always_comb begin
    case (addr)
      2'd0:    rd_data = {28'd0, state_q, pause_q, autoEn_q};
      2'd1:    rd_data = {30'd0, sqSize_q};
      2'd2:    rd_data = {20'd0, sqColor_q};
      default: rd_data = 32'(period_q);
    endcase
  end

endmodule

// File: tb/tb_square_seq_ctrl.sv
// Directed bench for square_seq_ctrl: manual load, auto ping-pong, pause,
// exit-to-manual, zero period, back-to-back frames and async reset.
module tb_square_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        write;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        frame_start;
  logic [1:0]  sq_size;
  logic [11:0] sq_color;
  logic        step_tick;

  int checks;
  int failures;

  square_seq_ctrl #(.PERIOD_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cs          (cs),
    .write       (write),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .frame_start (frame_start),
    .sq_size     (sq_size),
    .sq_color    (sq_color),
    .step_tick   (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOuts(input string tag, input logic [1:0] sz, input logic [11:0] col,
                           input logic tk);
    checkOutput({tag, "_size"}, {30'd0, sq_size}, {30'd0, sz});
    checkOutput({tag, "_color"}, {20'd0, sq_color}, {20'd0, col});
    checkOutput({tag, "_tick"}, {31'd0, step_tick}, {31'd0, tk});
  endtask

  task automatic checkRead(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    checkOutput(tag, rd_data, exp);
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic pulse();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic writeWithFrame(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d; frame_start = 1'b1;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; frame_start = 1'b0;
  endtask

  logic [1:0]  expSize  [13] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3,
                                 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
  logic [11:0] expColor [13] = '{12'hF00, 12'hF00, 12'h00F, 12'h00F, 12'h0F0, 12'h0F0,
                                 12'hF00, 12'hF00, 12'h00F, 12'h00F, 12'h0F0, 12'h0F0,
                                 12'hF00};
  logic        expTick  [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; cs = 1'b0; write = 1'b0; addr = 2'd0; wr_data = 32'd0; frame_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    checkOuts("reset", 2'd0, 12'hF00, 1'b0);
    checkRead("reset_rd0", 2'd0, 32'd0);
    checkRead("reset_rd2", 2'd2, 32'h0000_0F00);
    checkRead("reset_rd3", 2'd3, 32'd60);

    pulse();
    checkOuts("first_frame", 2'd0, 12'hF00, 1'b0);

    applyStimulus(2'd1, 32'd3);
    applyStimulus(2'd2, 32'h0AB);
    checkOuts("man_before_pulse", 2'd0, 12'hF00, 1'b0);
    pulse();
    checkOuts("man_after_pulse", 2'd3, 12'h0AB, 1'b0);
    checkRead("man_rd1", 2'd1, 32'd3);
    checkRead("man_rd2", 2'd2, 32'h0AB);

    applyStimulus(2'd1, 32'd0);
    applyStimulus(2'd2, 32'hF00);
    pulse();
    checkOuts("man_restore", 2'd0, 12'hF00, 1'b0);

    applyStimulus(2'd3, 32'd2);
    applyStimulus(2'd0, 32'd1);
    for (int i = 0; i < 13; i++) begin
      pulse();
      checkOuts($sformatf("auto_p%0d", i + 1), expSize[i], expColor[i], expTick[i]);
      if (i == 0) checkRead("auto_state_up", 2'd0, 32'd5);
    end
    @(negedge clk);
    checkOutput("tick_one_cycle", {31'd0, step_tick}, 32'd0);
    checkRead("auto_state_down", 2'd0, 32'd9);

    pulse();
    checkOuts("pre_pause", 2'd0, 12'hF00, 1'b0);
    applyStimulus(2'd0, 32'd3);
    for (int i = 0; i < 5; i++) begin
      pulse();
      checkOuts($sformatf("pause_p%0d", i + 1), 2'd0, 12'hF00, 1'b0);
    end
    applyStimulus(2'd0, 32'd1);
    pulse();
    checkOuts("resume_step", 2'd1, 12'h00F, 1'b1);

    pulse();
    checkOuts("resume_p2", 2'd1, 12'h00F, 1'b0);
    pulse();
    checkOuts("resume_p3", 2'd2, 12'h0F0, 1'b1);
    pulse();
    checkOuts("resume_p4", 2'd2, 12'h0F0, 1'b0);

    applyStimulus(2'd1, 32'd2);
    applyStimulus(2'd2, 32'h123);
    checkOuts("shadow_not_applied", 2'd2, 12'h0F0, 1'b0);
    writeWithFrame(2'd0, 32'd0);
    checkOuts("exit_frame_steps", 2'd3, 12'hF00, 1'b1);
    pulse();
    checkOuts("back_to_manual", 2'd2, 12'h123, 1'b0);
    checkRead("manual_state", 2'd0, 32'd0);

    applyStimulus(2'd3, 32'd0);
    applyStimulus(2'd0, 32'd1);
    checkRead("period_zero_rd", 2'd3, 32'd0);
    pulse();
    checkOuts("p0_enter_up", 2'd2, 12'h123, 1'b0);
    pulse();
    checkOuts("p0_step1", 2'd3, 12'h231, 1'b1);
    pulse();
    checkOuts("p0_step2", 2'd2, 12'h312, 1'b1);

    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    checkOuts("b2b_first", 2'd1, 12'h123, 1'b1);
    @(negedge clk);
    frame_start = 1'b0;
    checkOuts("b2b_second", 2'd0, 12'h231, 1'b1);

    @(negedge clk);
    frame_start = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOuts("async_reset", 2'd0, 12'hF00, 1'b0);
    checkRead("async_reset_rd0", 2'd0, 32'd0);
    checkRead("async_reset_rd3", 2'd3, 32'd60);
    frame_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pulse();
    checkOuts("after_reset_frame", 2'd0, 12'hF00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
